mem_lsu: RTL and testbench

- Memory-stage load/store unit: producer side of the MEM/WB pipeline register.
- Turns a MEM-stage access into a request/response transaction on the data bus and formats load data for writeback.
- Drives stall_o, which feeds the MEM/WB register stall input and all upstream stages.
- Holds the pipeline until the access completes; releases it for exactly one cycle with load data valid.

---
 rtl/mem_lsu_pkg.sv | 17 +
 rtl/lsu_load_align.sv | 19 +
 rtl/mem_lsu.sv | 90 +++++++++
 tb/tb_mem_lsu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: size and state encodings plus request-formatting helpers for the load/store unit
package mem_lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  // size 3 falls through to word
  function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? 4'b0011 << {a[1], 1'b0} : 4'hF;
  endfunction
  function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] w);
    return size == SZ_BYTE ? {4{w[7:0]}} : size == SZ_HALF ? {2{w[15:0]}} : w;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the load lane from a bus word and zero/sign-extends it
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] res
);
  logic [7:0]  b;
  logic [15:0] h;
  // lane pick, then extension by access size
  always_comb begin
    b = rdata[8*a +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    res = size == SZ_BYTE ? {{24{sign & b[7]}}, b} : size == SZ_HALF ? {{16{sign & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit driving the data bus and MEM/WB load data; LSU_ALIGN_EXC_EN adds exc_ale_o
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              d_req_o,
  output logic              d_wr_o,
  output logic [3:0]        d_be_o,
  output logic [ADDR_W-1:0] d_addr_o,
  output logic [DATA_W-1:0] d_wdata_o,
  input  logic              d_addr_ok_i,
  input  logic              d_data_ok_i,
  input  logic [DATA_W-1:0] d_rdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] ld_data_o
`ifdef LSU_ALIGN_EXC_EN
  ,
  output logic              exc_ale_o
`endif
);
  logic [1:0]        state, nxt, size_q, a_q;
  logic              sign_q, drop, access, go, cap;
  logic [DATA_W-1:0] ld_fmt;
  assign access = valid_i & (mem_rd_i | mem_wr_i) & ~clear;
`ifdef LSU_ALIGN_EXC_EN
  logic mis;
  assign mis = (size_i == SZ_HALF & addr_i[0]) | (size_i[1] & |addr_i[1:0]);
  assign exc_ale_o = state == ST_IDLE & access & mis;
  assign go = access & ~mis;
`else
  assign go = access;
`endif
  assign d_req_o = state == ST_ADDR;
  // rst gates stall so the whole output set reads zero while reset is held
  assign stall_o = ~rst & ((state == ST_IDLE & go) | state == ST_ADDR | state == ST_DATA);
  // clear in ADDR abandons the request; a flushed DATA access drains then skips DONE
  always_comb begin
    nxt = state == ST_IDLE ? (go ? ST_ADDR : ST_IDLE) :
          state == ST_ADDR ? (clear ? ST_IDLE : d_addr_ok_i ? (d_data_ok_i ? ST_DONE : ST_DATA) : ST_ADDR) :
          state == ST_DATA ? (d_data_ok_i ? ((drop | clear) ? ST_IDLE : ST_DONE) : ST_DATA) : ST_IDLE;
    cap = ~d_wr_o & d_data_ok_i & ~clear & ((state == ST_ADDR & d_addr_ok_i) | (state == ST_DATA & ~drop));
  end
  lsu_load_align u_align (
    .rdata(d_rdata_i),
    .a    (a_q),
    .size (size_q),
    .sign (sign_q),
    .res  (ld_fmt)
  );
  // state, latched request fields, drop flag and formatted load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      d_wr_o    <= 1'b0;
      d_be_o    <= '0;
      d_addr_o  <= '0;
      d_wdata_o <= '0;
      size_q    <= '0;
      a_q       <= '0;
      sign_q    <= 1'b0;
      drop      <= 1'b0;
      ld_data_o <= '0;
    end else begin
      state <= nxt;
      drop  <= state == ST_DATA & ~d_data_ok_i & (drop | clear);
      if (state == ST_IDLE && go) begin
        d_wr_o    <= mem_wr_i;
        d_be_o    <= lsu_be(size_i, addr_i[1:0]);
        d_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
        d_wdata_o <= lsu_wdata(size_i, wdata_i);
        size_q    <= size_i;
        a_q       <= addr_i[1:0];
        sign_q    <= sign_ext_i;
      end
      if (cap) ld_data_o <= ld_fmt;
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu; LSU_ALIGN_EXC_EN selects the alignment-exception scenario
module tb_mem_lsu;
  logic        clk = 0, rst = 1, clear = 0, valid_i = 0, mem_rd_i = 0, mem_wr_i = 0, sign_ext_i = 0;
  logic [1:0]  size_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, d_rdata_i = 0;
  logic        d_addr_ok_i = 0, d_data_ok_i = 0;
  logic        d_req_o, d_wr_o, stall_o;
  logic [3:0]  d_be_o;
  logic [31:0] d_addr_o, d_wdata_o, ld_data_o;
  int          checks = 0, failures = 0;
`ifdef LSU_ALIGN_EXC_EN
  logic        exc_ale_o;
`endif

  mem_lsu dut (
    .clk(clk), .rst(rst), .clear(clear), .valid_i(valid_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .size_i(size_i), .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .d_req_o(d_req_o), .d_wr_o(d_wr_o), .d_be_o(d_be_o), .d_addr_o(d_addr_o), .d_wdata_o(d_wdata_o),
    .d_addr_ok_i(d_addr_ok_i), .d_data_ok_i(d_data_ok_i), .d_rdata_i(d_rdata_i),
    .stall_o(stall_o), .ld_data_o(ld_data_o)
`ifdef LSU_ALIGN_EXC_EN
    , .exc_ale_o(exc_ale_o)
`endif
  );

  always #5 clk = ~clk;

  task step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task idle_in;
    valid_i = 0; mem_rd_i = 0; mem_wr_i = 0; clear = 0; d_addr_ok_i = 0; d_data_ok_i = 0;
  endtask

  task start(input logic wr, input logic [1:0] sz, input logic sx, input logic [31:0] a, input logic [31:0] w);
    valid_i = 1; mem_rd_i = ~wr; mem_wr_i = wr; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = w;
  endtask

  task test_reset;
    @(negedge clk);
    checks++; if (d_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", d_req_o); end
    checks++; if (d_be_o !== 4'h0) begin failures++; $display("FAIL rst_be got=%h exp=0", d_be_o); end
    checks++; if (d_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", d_addr_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    checks++; if (ld_data_o !== 32'h0) begin failures++; $display("FAIL rst_ld got=%h exp=0", ld_data_o); end
    rst = 0;
  endtask

  task test_lw_fast;
    start(0, 2, 0, 32'h100, 0);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL lw_stall_idle got=%b exp=1", stall_o); end
    step;
    checks++; if (d_req_o !== 1'b1) begin failures++; $display("FAIL lw_req got=%b exp=1", d_req_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL lw_stall_addr got=%b exp=1", stall_o); end
    checks++; if (d_addr_o !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=100", d_addr_o); end
    checks++; if (d_be_o !== 4'hF) begin failures++; $display("FAIL lw_be got=%h exp=f", d_be_o); end
    d_addr_ok_i = 1; d_data_ok_i = 1; d_rdata_i = 32'hDEADBEEF;
    step;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lw_stall_done got=%b exp=0", stall_o); end
    checks++; if (d_req_o !== 1'b0) begin failures++; $display("FAIL lw_req_done got=%b exp=0", d_req_o); end
    checks++; if (ld_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_ld got=%h exp=deadbeef", ld_data_o); end
    idle_in;
    step;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lw_stall_after got=%b exp=0", stall_o); end
  endtask

  task test_lb_wait;
    start(0, 0, 1, 32'h103, 0);
    step;
    checks++; if (d_be_o !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", d_be_o); end
    checks++; if (d_addr_o !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=100", d_addr_o); end
    step;
    checks++; if (d_req_o !== 1'b1) begin failures++; $display("FAIL lb_req_wait got=%b exp=1", d_req_o); end
    d_addr_ok_i = 1;
    step;
    d_addr_ok_i = 0;
    checks++; if (d_req_o !== 1'b0) begin failures++; $display("FAIL lb_req_data got=%b exp=0", d_req_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL lb_stall_data got=%b exp=1", stall_o); end
    step;
    step;
    d_data_ok_i = 1; d_rdata_i = 32'h80FFFF7F;
    step;
    checks++; if (ld_data_o !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_ld got=%h exp=ffffff80", ld_data_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lb_stall_done got=%b exp=0", stall_o); end
    idle_in;
    step;
  endtask

  task test_sh;
    start(1, 1, 0, 32'h206, 32'h0000ABCD);
    step;
    checks++; if (d_wr_o !== 1'b1) begin failures++; $display("FAIL sh_wr got=%b exp=1", d_wr_o); end
    checks++; if (d_be_o !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", d_be_o); end
    checks++; if (d_wdata_o !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", d_wdata_o); end
    checks++; if (d_addr_o !== 32'h204) begin failures++; $display("FAIL sh_addr got=%h exp=204", d_addr_o); end
    d_addr_ok_i = 1;
    step;
    d_addr_ok_i = 0; d_data_ok_i = 1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL sh_stall_data got=%b exp=1", stall_o); end
    step;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL sh_stall_done got=%b exp=0", stall_o); end
    checks++; if (ld_data_o !== 32'hFFFFFF80) begin failures++; $display("FAIL sh_ld_hold got=%h exp=ffffff80", ld_data_o); end
    idle_in;
    step;
  endtask

  task test_sb_lh;
    start(1, 0, 0, 32'h001, 32'h1234565A);
    step;
    checks++; if (d_be_o !== 4'b0010) begin failures++; $display("FAIL sb_be got=%b exp=0010", d_be_o); end
    checks++; if (d_wdata_o !== 32'h5A5A5A5A) begin failures++; $display("FAIL sb_wdata got=%h exp=5a5a5a5a", d_wdata_o); end
    d_addr_ok_i = 1; d_data_ok_i = 1;
    step;
    idle_in;
    step;
    start(0, 1, 0, 32'h102, 0);
    step;
    d_addr_ok_i = 1; d_data_ok_i = 1; d_rdata_i = 32'h80011234;
    step;
    checks++; if (ld_data_o !== 32'h00008001) begin failures++; $display("FAIL lh_ld got=%h exp=00008001", ld_data_o); end
    idle_in;
    step;
  endtask

  task test_clear_addr;
    start(0, 2, 0, 32'h300, 0);
    step;
    checks++; if (d_req_o !== 1'b1) begin failures++; $display("FAIL clra_req got=%b exp=1", d_req_o); end
    clear = 1;
    step;
    checks++; if (d_req_o !== 1'b0) begin failures++; $display("FAIL clra_req_drop got=%b exp=0", d_req_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL clra_stall got=%b exp=0", stall_o); end
    checks++; if (ld_data_o !== 32'h00008001) begin failures++; $display("FAIL clra_ld got=%h exp=00008001", ld_data_o); end
    idle_in;
    step;
  endtask

  task test_clear_data;
    start(0, 2, 0, 32'h400, 0);
    step;
    d_addr_ok_i = 1;
    step;
    d_addr_ok_i = 0; clear = 1; d_rdata_i = 32'h12345678;
    step;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL clrd_stall got=%b exp=1", stall_o); end
    checks++; if (d_req_o !== 1'b0) begin failures++; $display("FAIL clrd_req got=%b exp=0", d_req_o); end
    idle_in;
    step;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL clrd_drain got=%b exp=1", stall_o); end
    d_data_ok_i = 1;
    start(0, 2, 0, 32'h500, 0);
    step;
    d_data_ok_i = 0;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL clrd_no_done got=%b exp=1", stall_o); end
    checks++; if (ld_data_o !== 32'h00008001) begin failures++; $display("FAIL clrd_ld got=%h exp=00008001", ld_data_o); end
  endtask

  task test_rst_data;
    step;
    checks++; if (d_addr_o !== 32'h500) begin failures++; $display("FAIL rstd_addr got=%h exp=500", d_addr_o); end
    d_addr_ok_i = 1;
    step;
    d_addr_ok_i = 0;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rstd_stall_pre got=%b exp=1", stall_o); end
    #2 rst = 1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rstd_stall got=%b exp=0", stall_o); end
    checks++; if (d_addr_o !== 32'h0) begin failures++; $display("FAIL rstd_addr0 got=%h exp=0", d_addr_o); end
    checks++; if (d_be_o !== 4'h0) begin failures++; $display("FAIL rstd_be got=%h exp=0", d_be_o); end
    checks++; if (ld_data_o !== 32'h0) begin failures++; $display("FAIL rstd_ld got=%h exp=0", ld_data_o); end
    checks++; if (d_req_o !== 1'b0) begin failures++; $display("FAIL rstd_req got=%b exp=0", d_req_o); end
    @(negedge clk);
    rst = 0;
    idle_in;
    step;
  endtask

  task test_misaligned;
    start(0, 2, 0, 32'h102, 0);
`ifdef LSU_ALIGN_EXC_EN
    #1;
    checks++; if (exc_ale_o !== 1'b1) begin failures++; $display("FAIL ale_exc got=%b exp=1", exc_ale_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL ale_stall got=%b exp=0", stall_o); end
    step;
    checks++; if (d_req_o !== 1'b0) begin failures++; $display("FAIL ale_req got=%b exp=0", d_req_o); end
`else
    step;
    checks++; if (d_addr_o !== 32'h100) begin failures++; $display("FAIL mis_addr got=%h exp=100", d_addr_o); end
    checks++; if (d_be_o !== 4'hF) begin failures++; $display("FAIL mis_be got=%h exp=f", d_be_o); end
    d_addr_ok_i = 1; d_data_ok_i = 1; d_rdata_i = 32'hCAFEF00D;
    step;
    checks++; if (ld_data_o !== 32'hCAFEF00D) begin failures++; $display("FAIL mis_ld got=%h exp=cafef00d", ld_data_o); end
`endif
    idle_in;
    step;
  endtask

  initial begin
    test_reset;
    test_lw_fast;
    test_lb_wait;
    test_sh;
    test_sb_lh;
    test_clear_addr;
    test_clear_data;
    test_rst_data;
    test_misaligned;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
